// File: rtl/or16_arb_pkg.sv
// Shared constants for the or16_share_arbiter slice: datapath width, opcodes, FSM encoding.
package or16_arb_pkg;

    localparam int W = 16;

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/or16_share_arbiter_if.sv
// Request/response bundle between NREQ requesters (master) and the shared logic unit arbiter (slave).
interface or16_share_arbiter_if
    import or16_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) ();

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [W*NREQ-1:0] req_a;
    logic [W*NREQ-1:0] req_b;
    logic [2*NREQ-1:0] req_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_data;
    logic [IDW-1:0]    rsp_id;
    logic              busy;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, busy
    );

endinterface

// File: rtl/logic16_unit.sv
// Combinational 16-bit bitwise unit: one gate bank per opcode, result picked by op_i.
module logic16_unit
    import or16_arb_pkg::*;
(
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [1:0]   op_i,
    output logic [W-1:0] out_o
);

    logic [W-1:0] or_v;
    logic [W-1:0] and_v;
    logic [W-1:0] xor_v;
    logic [W-1:0] not_v;

    assign or_v  = a_i | b_i;
    assign and_v = a_i & b_i;
    assign xor_v = a_i ^ b_i;
    assign not_v = ~a_i;

    // NOTE: every path assigns out_o (default first), so no latch is inferred.
    always_comb begin
        out_o = or_v;
        case (op_i)
            OP_OR:   out_o = or_v;
            OP_AND:  out_o = and_v;
            OP_XOR:  out_o = xor_v;
            OP_NOT:  out_o = not_v;
            default: out_o = or_v;
        endcase
    end

endmodule

// File: rtl/or16_share_arbiter.sv
// Round-robin share of one logic16_unit among NREQ requesters; accept -> execute -> respond.
// Optional per-requester grant counters are built when OR16_ARB_STATS_EN is defined.
module or16_share_arbiter
    import or16_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic clk,
    input  logic rst_n,
`ifdef OR16_ARB_STATS_EN
    input  logic              stats_clr,
    output logic [W*NREQ-1:0] grant_cnt,
`endif
    or16_share_arbiter_if.slave bus
);

    state_t         state_q;
    logic [IDW-1:0] last_grant_q;
    logic [IDW-1:0] id_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [1:0]     op_q;
    logic           rsp_valid_q;
    logic [W-1:0]   rsp_data_q;
    logic [IDW-1:0] rsp_id_q;

    logic            grant_valid;
    logic [IDW-1:0]  grant_idx;
    logic [NREQ-1:0] req_ready;
    logic            accept;
    logic [W-1:0]    a_sel;
    logic [W-1:0]    b_sel;
    logic [1:0]      op_sel;
    logic [W-1:0]    alu_out;

    // Search starts just after the last winner and wraps, so every waiting requester is reached.
    always_comb begin
        int unsigned    pos;
        logic [IDW-1:0] idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        pos         = 0;
        idx         = '0;
        for (int k = 1; k <= NREQ; k++) begin
            pos = (int'(last_grant_q) + k) % NREQ;
            idx = IDW'(pos);
            if (!grant_valid && bus.req_valid[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    // req_ready is also gated by rst_n so it reads 0 for the whole reset window.
    always_comb begin
        req_ready = '0;
        a_sel     = '0;
        b_sel     = '0;
        op_sel    = OP_OR;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                req_ready[i] = rst_n && (state_q == IDLE) && grant_valid;
                a_sel        = bus.req_a[W*i +: W];
                b_sel        = bus.req_b[W*i +: W];
                op_sel       = bus.req_op[2*i +: 2];
            end
        end
    end

    assign accept = |(req_ready & bus.req_valid);

    logic16_unit u_logic16 (
        .a_i  (a_q),
        .b_i  (b_q),
        .op_i (op_q),
        .out_o(alu_out)
    );

    // NOTE: sequential state uses non-blocking assignments only; every register is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= IDW'(NREQ - 1);
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= OP_OR;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q          <= a_sel;
                        b_q          <= b_sel;
                        op_q         <= op_sel;
                        id_q         <= grant_idx;
                        last_grant_q <= grant_idx;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_q  <= alu_out;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy      = (state_q != IDLE);

`ifdef OR16_ARB_STATS_EN
    logic [W*NREQ-1:0] cnt_q;

    // Clear wins over a same-cycle grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (stats_clr) begin
            cnt_q <= '0;
        end else if (accept) begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant_idx == IDW'(i)) begin
                    cnt_q[W*i +: W] <= cnt_q[W*i +: W] + 16'd1;
                end
            end
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_or16_share_arbiter.sv
// Directed self-checking bench for or16_share_arbiter (NREQ=4); stats checks build with OR16_ARB_STATS_EN.
module tb_or16_share_arbiter;
    import or16_arb_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    or16_share_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) ifc ();

`ifdef OR16_ARB_STATS_EN
    logic              stats_clr;
    logic [W*NREQ-1:0] grant_cnt;

    or16_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stats_clr(stats_clr),
        .grant_cnt(grant_cnt),
        .bus      (ifc.slave)
    );
`else
    or16_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (ifc.slave)
    );
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        ifc.req_a[16*i +: 16] = a;
        ifc.req_b[16*i +: 16] = b;
        ifc.req_op[2*i +: 2]  = op;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        ifc.req_valid = 4'b1111;
        ifc.rsp_ready = 1'b0;
        ifc.req_a     = '0;
        ifc.req_b     = '0;
        ifc.req_op    = '0;
        #12;
        n_checks++; if (ifc.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", ifc.rsp_valid); end
        n_checks++; if (ifc.rsp_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 0000", ifc.rsp_data); end
        n_checks++; if (ifc.rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id: got %0d want 0", ifc.rsp_id); end
        n_checks++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", ifc.busy); end
        n_checks++; if (ifc.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", ifc.req_ready); end
        ifc.req_valid = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        set_req(0, 16'h00F0, 16'h0F0F, OP_OR);
        ifc.req_valid = 4'b0001;
        ifc.rsp_ready = 1'b1;
        #1;
        n_checks++; if (ifc.req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_ready: got %b want 0001", ifc.req_ready); end
        tick();
        n_checks++; if (ifc.req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_ready_exec: got %b want 0000", ifc.req_ready); end
        n_checks++; if (ifc.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_exec: got %b want 1", ifc.busy); end
        n_checks++; if (ifc.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_exec: got %b want 0", ifc.rsp_valid); end
        ifc.req_valid = 4'b0000;
        tick();
        n_checks++; if (ifc.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 1", ifc.rsp_valid); end
        n_checks++; if (ifc.rsp_data !== 16'h0FFF) begin n_fail++; $display("FAIL single_rsp_data: got %h want 0fff", ifc.rsp_data); end
        n_checks++; if (ifc.rsp_id !== 2'd0) begin n_fail++; $display("FAIL single_rsp_id: got %0d want 0", ifc.rsp_id); end
        tick();
        n_checks++; if (ifc.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop: got %b want 0", ifc.rsp_valid); end
        n_checks++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b want 0", ifc.busy); end
        n_checks++; if (ifc.rsp_data !== 16'h0FFF) begin n_fail++; $display("FAIL single_data_kept: got %h want 0fff", ifc.rsp_data); end
    endtask

    task automatic test_fairness();
        logic [15:0] exp_data [4];
        int          order    [5];
        exp_data = '{16'h300C, 16'h003C, 16'h0C30, 16'h3C3C};
        order    = '{0, 1, 2, 3, 0};
        pulse_reset();
        set_req(0, 16'hF00F, 16'h3C3C, OP_AND);
        set_req(1, 16'h00FF, 16'h3C3C, OP_AND);
        set_req(2, 16'h0FF0, 16'h3C3C, OP_AND);
        set_req(3, 16'hFFFF, 16'h3C3C, OP_AND);
        ifc.rsp_ready = 1'b1;
        ifc.req_valid = 4'b1111;
        #1;
        for (int n = 0; n < 5; n++) begin
            n_checks++; if (ifc.req_ready !== 4'(1 << order[n])) begin n_fail++; $display("FAIL fair_grant[%0d]: got %b want %b", n, ifc.req_ready, 4'(1 << order[n])); end
            tick();
            tick();
            n_checks++; if (ifc.rsp_id !== 2'(order[n])) begin n_fail++; $display("FAIL fair_rsp_id[%0d]: got %0d want %0d", n, ifc.rsp_id, order[n]); end
            n_checks++; if (ifc.rsp_data !== exp_data[order[n]]) begin n_fail++; $display("FAIL fair_rsp_data[%0d]: got %h want %h", n, ifc.rsp_data, exp_data[order[n]]); end
            if (n == 4) ifc.req_valid = 4'b0000;
            tick();
        end
        n_checks++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL fair_idle: got %b want 0", ifc.busy); end
    endtask

    task automatic test_backpressure();
        set_req(2, 16'hAAAA, 16'hFFFF, OP_XOR);
        ifc.rsp_ready = 1'b0;
        ifc.req_valid = 4'b0100;
        tick();
        ifc.req_valid = 4'b1111;
        tick();
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (ifc.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", c, ifc.rsp_valid); end
            n_checks++; if (ifc.rsp_data !== 16'h5555) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want 5555", c, ifc.rsp_data); end
            n_checks++; if (ifc.rsp_id !== 2'd2) begin n_fail++; $display("FAIL bp_id[%0d]: got %0d want 2", c, ifc.rsp_id); end
            n_checks++; if (ifc.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b want 0000", c, ifc.req_ready); end
            n_checks++; if (ifc.busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy[%0d]: got %b want 1", c, ifc.busy); end
            tick();
        end
        ifc.rsp_ready = 1'b1;
        ifc.req_valid = 4'b0000;
        tick();
        n_checks++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got %b want 0", ifc.busy); end
        n_checks++; if (ifc.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop: got %b want 0", ifc.rsp_valid); end
    endtask

    task automatic test_pointer_wrap();
        set_req(3, 16'h1234, 16'hFFFF, OP_NOT);
        set_req(1, 16'h8001, 16'h0110, OP_OR);
        ifc.rsp_ready = 1'b1;
        ifc.req_valid = 4'b1000;
        tick();
        ifc.req_valid = 4'b0000;
        tick();
        n_checks++; if (ifc.rsp_data !== 16'hEDCB) begin n_fail++; $display("FAIL wrap_not_data: got %h want edcb", ifc.rsp_data); end
        n_checks++; if (ifc.rsp_id !== 2'd3) begin n_fail++; $display("FAIL wrap_not_id: got %0d want 3", ifc.rsp_id); end
        tick();
        ifc.req_valid = 4'b1010;
        #1;
        n_checks++; if (ifc.req_ready !== 4'b0010) begin n_fail++; $display("FAIL wrap_grant1: got %b want 0010", ifc.req_ready); end
        tick();
        ifc.req_valid = 4'b1000;
        tick();
        n_checks++; if (ifc.rsp_id !== 2'd1) begin n_fail++; $display("FAIL wrap_rsp_id1: got %0d want 1", ifc.rsp_id); end
        n_checks++; if (ifc.rsp_data !== 16'h8111) begin n_fail++; $display("FAIL wrap_rsp_data1: got %h want 8111", ifc.rsp_data); end
        tick();
        n_checks++; if (ifc.req_ready !== 4'b1000) begin n_fail++; $display("FAIL wrap_grant3: got %b want 1000", ifc.req_ready); end
        tick();
        ifc.req_valid = 4'b0000;
        tick();
        n_checks++; if (ifc.rsp_id !== 2'd3) begin n_fail++; $display("FAIL wrap_rsp_id3: got %0d want 3", ifc.rsp_id); end
        n_checks++; if (ifc.rsp_data !== 16'hEDCB) begin n_fail++; $display("FAIL wrap_rsp_data3: got %h want edcb", ifc.rsp_data); end
        tick();
    endtask

    task automatic test_async_reset();
        set_req(0, 16'h0F0F, 16'h00FF, OP_XOR);
        ifc.rsp_ready = 1'b1;
        ifc.req_valid = 4'b0001;
        tick();
        n_checks++; if (ifc.busy !== 1'b1) begin n_fail++; $display("FAIL ar_busy_exec: got %b want 1", ifc.busy); end
        #2;
        rst_n         = 1'b0;
        ifc.req_valid = 4'b1111;
        #1;
        n_checks++; if (ifc.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b want 0", ifc.rsp_valid); end
        n_checks++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL ar_busy: got %b want 0", ifc.busy); end
        n_checks++; if (ifc.req_ready !== 4'b0000) begin n_fail++; $display("FAIL ar_ready: got %b want 0000", ifc.req_ready); end
        n_checks++; if (ifc.rsp_data !== 16'h0000) begin n_fail++; $display("FAIL ar_data: got %h want 0000", ifc.rsp_data); end
        tick();
        n_checks++; if (ifc.busy !== 1'b0) begin n_fail++; $display("FAIL ar_held: got %b want 0", ifc.busy); end
        rst_n = 1'b1;
        #1;
        n_checks++; if (ifc.req_ready !== 4'b0001) begin n_fail++; $display("FAIL ar_first_grant: got %b want 0001", ifc.req_ready); end
        tick();
        ifc.req_valid = 4'b0000;
        tick();
        n_checks++; if (ifc.rsp_id !== 2'd0) begin n_fail++; $display("FAIL ar_rsp_id: got %0d want 0", ifc.rsp_id); end
        n_checks++; if (ifc.rsp_data !== 16'h0FF0) begin n_fail++; $display("FAIL ar_rsp_data: got %h want 0ff0", ifc.rsp_data); end
        tick();
    endtask

`ifdef OR16_ARB_STATS_EN
    task automatic test_stats();
        pulse_reset();
        set_req(2, 16'h0001, 16'h0002, OP_OR);
        ifc.rsp_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            ifc.req_valid = 4'b0100;
            tick();
            ifc.req_valid = 4'b0000;
            tick();
            tick();
        end
        n_checks++; if (grant_cnt[32 +: 16] !== 16'd3) begin n_fail++; $display("FAIL stats_cnt2: got %0d want 3", grant_cnt[32 +: 16]); end
        n_checks++; if (grant_cnt[0 +: 16] !== 16'd0) begin n_fail++; $display("FAIL stats_cnt0: got %0d want 0", grant_cnt[0 +: 16]); end
        ifc.req_valid = 4'b0100;
        stats_clr     = 1'b1;
        tick();
        stats_clr     = 1'b0;
        ifc.req_valid = 4'b0000;
        n_checks++; if (grant_cnt !== '0) begin n_fail++; $display("FAIL stats_clr: got %h want 0", grant_cnt); end
        tick();
        tick();
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
`ifdef OR16_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_pointer_wrap();
        test_async_reset();
`ifdef OR16_ARB_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
